result_ascii_emitter: RTL and testbench
=======================================

// Module: result_ascii_emitter
// PURPOSE
//  Downstream stage of the expression calculator. It takes the 32-bit unsigned result and converts it to decimal with a
//  sequential double-dabble. It then streams the decimal digits MSB-first as ASCII characters over a valid/ready handshake.
//  The consumer is the UART transmitter or the character-display driver.
// PARAMETERS
//  WIDTH   32  bit width of the input value
//  DIGITS  10  BCD digits held; must be >= ceil(WIDTH*log10(2)); 10 for WIDTH=32
// PORTS
//  clk         in   1      single system clock, rising edge
//  clr         in   1      asynchronous, active-high reset
//  start       in   1      request conversion of value; sampled only when busy==0
//  value       in   WIDTH  unsigned result from calculator; latched on accepted start
//  busy        out  1      high from accepted start until the done cycle
//  char_out    out  8      ASCII character ('0'..'9', optionally 8'h0A)
//  char_valid  out  1      char_out is valid
//  char_ready  in   1      consumer accepts char_out when char_valid & char_ready
//  done        out  1      one-cycle pulse after the last character is accepted
// BEHAVIOUR
//  Reset (clr high, async): state=IDLE; busy=0, char_valid=0, char_out=8'h00, done=0; shift/BCD/index regs cleared.
//  States: IDLE -> CONVERT -> EMIT (-> TERM if NEWLINE_EN) -> IDLE.
//  IDLE: start=1 at edge E0 -> latch value, clear BCD, bitcnt=WIDTH, go CONVERT; busy=1 after E0.
//  CONVERT: edges E1..E(WIDTH), one per edge:
//   - first, every nibble >=5 gets +3;
//   - then {bcd,shift} is shifted left by 1.
//  At E(WIDTH+1): go EMIT and load idx = index of the most significant nonzero digit (0 if all zero).
//   - Leading-zero suppression is combinational (priority encode).
//   - char_valid=1 after E(WIDTH+1), i.e. a fixed latency of WIDTH+1 edges from the start sample.
//  EMIT: char_out = 8'h30 + bcd[idx]; char_valid held high.
//   - While char_valid & !char_ready: char_out and char_valid stay stable.
//   - On accept with idx>0: idx--; the next char is valid the next cycle, so 1 char/clk with ready held high.
//   - On accept with idx==0: go IDLE (or TERM if NEWLINE_EN); char_valid drops.
//   - Interior and trailing zeros are emitted; only leading zeros are suppressed; value 0 emits a single '0'.
//  Completion: done=1 for exactly one cycle after the final accept. busy=0 in that same cycle; state IDLE.
//  start during busy=1 is ignored, no queuing. start in the done cycle (busy=0) is accepted.
//  value changes after the latch are ignored.
//  clr mid-operation: immediate abort to reset values; no done pulse; no partial character.
//  Arithmetic: unsigned only; BCD nibble add is 4-bit; no overflow possible with DIGITS as specified.
// CONFIGURATION
//  NEWLINE_EN defined: after the last digit is accepted, TERM presents char_out=8'h0A with char_valid=1.
//   - The handshake is identical to EMIT.
//   - done pulses after the newline is accepted.
//  NEWLINE_EN undefined: no TERM state; done pulses after the last digit is accepted.
// TESTING
//  1. value=7, start, ready=1 -> single char 8'h37, then done pulse; with NEWLINE_EN, 8'h37 then 8'h0A, then done.
//  2. value=0 -> exactly one char 8'h30; char_valid first high WIDTH+1 edges after the start edge.
//  3. value=32'hFFFFFFFF, ready held 1 -> "4294967295" on 10 consecutive cycles, no gaps; busy low with done.
//  4. value=1000, ready toggled 1,0,0,1,... -> "1000"; char_out stable throughout every stall; no character lost or repeated.
//  5. value=123, clr pulsed mid-CONVERT -> all outputs reset, no done; then value=45 -> "45" and done.
//  6. start value=12, then start value=99 while busy -> only "12" emitted; start with 99 in the done cycle -> "99" follows.

Source files
------------

// File: rtl/result_ascii_emitter.sv
// Converts an unsigned result to decimal (sequential double-dabble) and streams the digits MSB-first as ASCII.
// Optional feature: define NEWLINE_EN to append an 8'h0A character after the last digit.
`timescale 1ns/1ps
module result_ascii_emitter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT, S_TERM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;

    logic [BW-1:0]    bcd_adj;
    logic [3:0]       digit_arr [DIGITS];
    logic [IW-1:0]    lead_idx;
    logic [3:0]       cur_digit;

    // Per-nibble add-3 correction applied before every shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                 : bcd_q[gi*4 +: 4];
        assign digit_arr[gi] = bcd_q[gi*4 +: 4];
    end

    // Highest nonzero digit wins; an all-zero value points at digit 0 so it prints a single '0'.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                lead_idx = IW'(i);
            end
        end
    end

    assign cur_digit = digit_arr[idx_q];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            bitcnt_q <= bitcnt_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        bitcnt_d   = bitcnt_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        char_valid = 1'b0;
        char_out   = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d  = value;
                    bcd_d    = '0;
                    bitcnt_d = CW'(WIDTH);
                    state_d  = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (bitcnt_q != '0) begin
                    {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                    bitcnt_d         = bitcnt_q - CW'(1);
                end else begin
                    idx_d   = lead_idx;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                char_valid = 1'b1;
                char_out   = 8'h30 + {4'h0, cur_digit};
                if (char_ready) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IW'(1);
                    end else begin
`ifdef NEWLINE_EN
                        state_d = S_TERM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef NEWLINE_EN
            S_TERM: begin
                char_valid = 1'b1;
                char_out   = 8'h0A;
                if (char_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_result_ascii_emitter.sv
// Self-checking bench for result_ascii_emitter: directed cases plus random values against a string-based decimal model.
`timescale 1ns/1ps
module tb_result_ascii_emitter;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             busy;
    logic [7:0]       char_out;
    logic             char_valid;
    logic             char_ready = 1'b0;
    logic             done;

    int  n_assert = 0;
    int  n_fail   = 0;
    byte exp_q[$];

    result_ascii_emitter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .value      (value),
        .busy       (busy),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the decimal text of the value, leading zeros never present, optional newline.
    task automatic build_exp(input logic [31:0] v);
        string s;
        s = $sformatf("%0d", v);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Called at a negedge; leaves the bench at the negedge after the start edge.
    task automatic start_conv(input logic [31:0] v);
        build_exp(v);
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("no_valid_after_start", char_valid, 1'b0);
    endtask

    // Waits for the first character; a noisy wait hammers start/value to prove they are ignored while busy.
    task automatic wait_valid(input bit noisy);
        int cycles = 0;
        while (!char_valid && cycles < 200) begin
            if (noisy) begin
                start = 1'b1;
                value = (cycles % 2 == 0) ? 32'd99 : $urandom;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("first_valid_latency", cycles, WIDTH + 1);
    endtask

    // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: random ready. Ends in the done cycle.
    task automatic emit_check(input int mode);
        int guard = 0;
        int k = 0;
        bit r;
        while (exp_q.size() != 0 && guard < 400) begin
            check("valid_held", char_valid, 1'b1);
            check("char", char_out, exp_q[0]);
            check("busy_emit", busy, 1'b1);
            check("done_low_emit", done, 1'b0);
            case (mode)
                0:       r = 1'b1;
                1:       r = (k % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            k++;
            char_ready = r;
            @(negedge clk);
            if (r) void'(exp_q.pop_front());
            guard++;
        end
        char_ready = 1'b0;
        check("emit_timeout", exp_q.size(), 0);
        check("done_pulse", done, 1'b1);
        check("busy_low_done", busy, 1'b0);
        check("valid_low_done", char_valid, 1'b0);
        check("char_zero_done", char_out, 8'h00);
    endtask

    task automatic done_drops;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    task automatic run(input logic [31:0] v, input int mode);
        start_conv(v);
        wait_valid(1'b0);
        emit_check(mode);
        done_drops();
    endtask

    initial begin
        bit seen;
        // Reset state.
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", char_valid, 1'b0);
        check("rst_char", char_out, 8'h00);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        run(32'd7, 0);
        run(32'd0, 0);
        run(32'hFFFF_FFFF, 0);
        run(32'd1000, 1);

        // Abort mid-conversion.
        start_conv(32'd123);
        repeat (10) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_busy", busy, 1'b0);
        check("clr_valid", char_valid, 1'b0);
        check("clr_char", char_out, 8'h00);
        check("clr_done", done, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done || char_valid || busy) seen = 1'b1;
        end
        check("clr_no_activity", seen, 1'b0);
        run(32'd45, 2);

        // Start while busy is ignored; start in the done cycle is accepted.
        start_conv(32'd12);
        wait_valid(1'b1);
        emit_check(0);
        start_conv(32'd99);
        wait_valid(1'b0);
        emit_check(1);
        done_drops();

        // Random values across several magnitudes with random back-pressure.
        for (int t = 0; t < 9; t++) begin
            logic [31:0] rv;
            case (t % 3)
                0:       rv = $urandom;
                1:       rv = $urandom % 100000;
                default: rv = $urandom % 10;
            endcase
            run(rv, 2);
        end
        run(32'd1_000_000_000, 0);
        run(32'd10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
